pl_ctrl: RTL

Pipeline controller for the five-stage core: drives the master side of the `pipeline_io` interface into every stage register (IF, ID, EX, MEM) with per-stage `stall`/`flush`, and supplies `new_pc` on redirects.
- Resolves memory wait, load-use hazards, fetch wait, exceptions, `eret` and external interrupts into one consistent set of control signals per cycle.
- Owns the trap state: EPC, cause and interrupt enable/mask.

---
 rtl/cpu_ctrl_pkg.sv | 24 ++
 rtl/pipeline_io.sv | 8 +
 rtl/pl_irq_pri.sv | 24 ++
 rtl/pl_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the core pipeline control logic.
package cpu_ctrl_pkg;

  // Word address (byte address >> 2) of a 32-bit core.
  typedef logic [29:0] WordAddr;

  localparam int unsigned CAUSE_W        = 4;
  localparam WordAddr     DEF_EXP_VECTOR = 30'h0000_0100;

  typedef enum logic [1:0] {
    RUN,
    PEND,
    TRAP
  } pl_state_t;

  typedef enum logic [2:0] {
    ILLEGAL,
    MISALIGN,
    OVERFLOW,
    SYSCALL,
    BUS_ERR
  } exp_code_t;

endpackage

// File: rtl/pipeline_io.sv
// Per-stage pipeline register control: stall holds the stage, flush inserts a bubble.
interface pipeline_io;
  logic stall;
  logic flush;

  modport master (output stall, output flush);
  modport slave  (input  stall, input  flush);
endinterface

// File: rtl/pl_irq_pri.sv
// Lowest-index priority encoder over the unmasked interrupt lines.
module pl_irq_pri #(
  parameter int unsigned IRQ_W = 8
) (
  input  logic [IRQ_W-1:0] irq,
  input  logic [IRQ_W-1:0] int_mask,
  output logic             any,
  output logic [2:0]       idx
);

  logic [IRQ_W-1:0] w_act;

  assign w_act = irq & ~int_mask;
  assign any   = |w_act;

  // Scan from the top so the lowest active line is the last one written.
  always_comb begin
    idx = 3'd0;
    for (int i = int'(IRQ_W) - 1; i >= 0; i--) begin
      if (w_act[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/pl_ctrl.sv
// Pipeline controller: per-stage stall/flush, redirect PC and trap state.
// Optional interrupt path enabled with `define PL_CTRL_IRQ_EN.
module pl_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned IRQ_W      = 8,
  parameter WordAddr     EXP_VECTOR = DEF_EXP_VECTOR
) (
  input  logic               clk,
  input  logic               rst,
  pipeline_io.master         if_pl,
  pipeline_io.master         id_pl,
  pipeline_io.master         ex_pl,
  pipeline_io.master         mem_pl,
  output WordAddr            new_pc,
  input  logic               if_busy,
  input  logic               mem_busy,
  input  logic               ld_hazard,
  input  logic               exp_valid,
  input  logic [2:0]         exp_code,
  input  WordAddr            exp_pc,
  input  logic               eret,
  input  WordAddr            id_pc,
  input  logic [IRQ_W-1:0]   irq,
  input  logic               csr_we,
  input  logic [IRQ_W-1:0]   csr_wdata,
  output WordAddr            epc,
  output logic [CAUSE_W-1:0] cause,
  output logic               int_en,
  output logic [IRQ_W-1:0]   int_mask
);

  pl_state_t          r_state, w_state_d;
  logic [2:0]         r_pend_code;
  WordAddr            r_pend_pc;
  WordAddr            r_epc, w_epc_d;
  logic [CAUSE_W-1:0] r_cause, w_cause_d;
  logic               r_int_en, w_int_en_d;
  logic [IRQ_W-1:0]   r_int_mask, w_int_mask_d;
  WordAddr            r_new_pc, w_new_pc;
  logic [3:0]         w_stall, w_flush;  // {IF, ID, EX, MEM}
  logic               w_irq_any;
  logic [2:0]         w_irq_idx;
  logic               w_irq_take;
  logic               w_take_exp;
  logic [2:0]         w_exp_code;
  WordAddr            w_exp_pc;

`ifdef PL_CTRL_IRQ_EN
  pl_irq_pri #(
    .IRQ_W (IRQ_W)
  ) u_irq_pri (
    .irq      (irq),
    .int_mask (r_int_mask),
    .any      (w_irq_any),
    .idx      (w_irq_idx)
  );
  assign w_int_mask_d = csr_we ? csr_wdata : r_int_mask;
`else
  logic w_unused_irq;
  assign w_unused_irq = ^{irq, csr_we, csr_wdata};
  assign w_irq_any    = 1'b0;
  assign w_irq_idx    = 3'd0;
  assign w_int_mask_d = '1;
`endif

  // A latched exception is older than anything now in MEM, so it takes precedence.
  assign w_take_exp = !mem_busy && (exp_valid || (r_state == PEND));
  assign w_exp_code = (r_state == PEND) ? r_pend_code : exp_code;
  assign w_exp_pc   = (r_state == PEND) ? r_pend_pc   : exp_pc;
  assign w_irq_take = r_int_en && w_irq_any && !mem_busy;

  // Per-cycle priority resolution of stalls, flushes, redirect and trap updates.
  always_comb begin
    w_stall    = 4'b0000;
    w_flush    = 4'b0000;
    w_new_pc   = r_new_pc;
    w_state_d  = r_state;
    w_epc_d    = r_epc;
    w_cause_d  = r_cause;
    w_int_en_d = r_int_en;
    if (!rst) begin
      w_flush  = 4'b1000;
      w_new_pc = EXP_VECTOR;
    end else if (mem_busy) begin
      w_stall = 4'b1111;
      if (exp_valid && (r_state != PEND)) w_state_d = PEND;
    end else if (w_take_exp) begin
      w_flush    = 4'b1111;
      w_new_pc   = EXP_VECTOR;
      w_epc_d    = w_exp_pc;
      w_cause_d  = {1'b0, w_exp_code};
      w_int_en_d = 1'b0;
      w_state_d  = TRAP;
    end else if (eret) begin
      w_flush    = 4'b1111;
      w_new_pc   = r_epc;
      w_int_en_d = 1'b1;
      w_state_d  = RUN;
    end else if (w_irq_take) begin
      w_flush    = 4'b1111;
      w_new_pc   = EXP_VECTOR;
      w_epc_d    = id_pc;
      w_cause_d  = {1'b1, w_irq_idx};
      w_int_en_d = 1'b0;
      w_state_d  = TRAP;
    end else if (ld_hazard) begin
      w_stall = 4'b1100;
      w_flush = 4'b0010;
    end else if (if_busy) begin
      w_stall = 4'b1000;
      w_flush = 4'b0100;
    end
  end

  // Trap state, pending exception and last redirect target.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= RUN;
      r_pend_code <= 3'd0;
      r_pend_pc   <= '0;
      r_epc       <= '0;
      r_cause     <= '0;
      r_int_en    <= 1'b0;
      r_int_mask  <= '1;
      r_new_pc    <= EXP_VECTOR;
    end else begin
      r_state    <= w_state_d;
      r_epc      <= w_epc_d;
      r_cause    <= w_cause_d;
      r_int_en   <= w_int_en_d;
      r_int_mask <= w_int_mask_d;
      r_new_pc   <= w_new_pc;
      if (mem_busy && exp_valid && (r_state != PEND)) begin
        r_pend_code <= exp_code;
        r_pend_pc   <= exp_pc;
      end
    end
  end

  assign if_pl.stall  = w_stall[3];
  assign id_pl.stall  = w_stall[2];
  assign ex_pl.stall  = w_stall[1];
  assign mem_pl.stall = w_stall[0];
  assign if_pl.flush  = w_flush[3];
  assign id_pl.flush  = w_flush[2];
  assign ex_pl.flush  = w_flush[1];
  assign mem_pl.flush = w_flush[0];
  assign new_pc       = w_new_pc;
  assign epc          = r_epc;
  assign cause        = r_cause;
  assign int_en       = r_int_en;
  assign int_mask     = r_int_mask;

endmodule
